reg_bank: RTL and testbench

Parametrised bank of `NUM_REGS` configuration registers written from an asynchronous source through a synchronised four-phase req/ack handshake. Each write carries an address and data, and is acknowledged back to the source. Contents are exposed both as a flat bus and through a registered read port. It sits at the boundary between the UART receive/command side and the `clk`-domain datapath, and supersedes single-register capture blocks.

---
 rtl/reg_bank_pkg.sv | 8 +
 rtl/sync_ff.sv | 26 ++
 rtl/reg_bank.sv | 97 +++++++++
 tb/tb_reg_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the configuration register bank.
package reg_bank_pkg;

  typedef enum logic {IDLE, ACK} wr_state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser chain with synchronous reset.
module sync_ff
  import reg_bank_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two stages would not give metastability time to resolve.
  localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  (* ASYNC_REG = "TRUE" *) logic [N-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {N{RST_VAL}};
    else     chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/reg_bank.sv
// Register bank written through a synchronised four-phase req/ack handshake.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       NUM_REGS    = 4,
  parameter int unsigned       ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_din,
  output logic                         wr_ack,
  output logic                         wr_err,
  input  logic                         err_clr,
  output logic [NUM_REGS-1:0]          upd,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   all_regs
);

  logic                req_s;
  logic                addr_ok;
  wr_state_t           state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (wr_req),
    .q   (req_s)
  );

  always_comb addr_ok = (32'(wr_addr) < NUM_REGS);

  // wr_hit marks the written register; upd replays it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      wr_hit <= '0;
      upd    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_hit <= '0;
      upd    <= wr_hit;
      if (err_clr) wr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_s) begin
            state  <= ACK;
            wr_ack <= 1'b1;
            if (addr_ok) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                  regs[i]   <= wr_din;
                  wr_hit[i] <= 1'b1;
                end
              end
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        ACK: begin
          if (!req_s) begin
            state  <= IDLE;
            wr_ack <= 1'b0;
          end
        end
      endcase
    end
  end

  // Out-of-range addresses read as zero; same-cycle writes are not bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (rd_addr == ADDR_W'(i)) rd_data <= regs[i];
      end
    end
  end

  always_comb begin
    all_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) all_regs[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: 4-register bank plus a 3-register bank for range errors.
module tb_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_req, wr_ack, wr_err, err_clr;
  logic [1:0]  wr_addr, rd_addr;
  logic [7:0]  wr_din, rd_data;
  logic [3:0]  upd;
  logic [31:0] all_regs;

  logic        b_req, b_ack, b_err, b_clr;
  logic [1:0]  b_addr, b_rd_addr;
  logic [7:0]  b_din, b_rd_data;
  logic [2:0]  b_upd;
  logic [23:0] b_all;

  reg_bank #(.DATA_W(8), .NUM_REGS(4), .SYNC_STAGES(2), .RESET_VAL(8'h5C)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din),
    .wr_ack(wr_ack), .wr_err(wr_err), .err_clr(err_clr), .upd(upd),
    .rd_addr(rd_addr), .rd_data(rd_data), .all_regs(all_regs)
  );

  reg_bank #(.DATA_W(8), .NUM_REGS(3), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst), .wr_req(b_req), .wr_addr(b_addr), .wr_din(b_din),
    .wr_ack(b_ack), .wr_err(b_err), .err_clr(b_clr), .upd(b_upd),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .all_regs(b_all)
  );

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    int         ack_edges;
    logic [3:0] exp_upd;
    logic [7:0] exp_rd;
  } vec_t;

  int        checks = 0;
  int        errors = 0;
  int        upd_cnt = 0;
  int        b_upd_cnt = 0;
  wr_exp_t   sbq[$];
  wr_exp_t   mon_e;
  logic [7:0] m4 [4];
  vec_t      tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m4[i];
    return r;
  endfunction

  task automatic push(input logic [1:0] a, input logic [7:0] d);
    sbq.push_back('{addr: a, data: d});
    m4[a] = d;
  endtask

  task automatic wait_ack(input bit sel3, input logic lvl, output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sel3 ? b_ack : wr_ack) == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic rise4(input logic [1:0] a, input logic [7:0] d, output int n);
    @(negedge clk);
    wr_addr = a; wr_din = d; wr_req = 1'b1;
    push(a, d);
    wait_ack(1'b0, 1'b1, n);
  endtask

  task automatic fall4(output int n);
    @(negedge clk);
    wr_req = 1'b0;
    wait_ack(1'b0, 1'b0, n);
  endtask

  task automatic rise3(input logic [1:0] a, input logic [7:0] d, output int n);
    @(negedge clk);
    b_addr = a; b_din = d; b_req = 1'b1;
    wait_ack(1'b1, 1'b1, n);
  endtask

  task automatic fall3(output int n);
    @(negedge clk);
    b_req = 1'b0;
    wait_ack(1'b1, 1'b0, n);
  endtask

  // Scoreboard: every upd pulse must match the oldest outstanding write.
  always @(negedge clk) begin
    if (upd !== 4'b0) begin
      upd_cnt++;
      if (sbq.size() == 0) begin
        chk("upd_unexpected", 32'(upd), 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_upd", 32'(upd), 32'(4'b0001 << mon_e.addr));
        chk("sb_data", 32'(all_regs[int'(mon_e.addr)*8 +: 8]), 32'(mon_e.data));
      end
    end
    if (b_upd !== 3'b0) b_upd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, c0;
    tbl[0] = '{addr: 2'd0, din: 8'h12, ack_edges: 3, exp_upd: 4'b0001, exp_rd: 8'h12};
    tbl[1] = '{addr: 2'd1, din: 8'h34, ack_edges: 3, exp_upd: 4'b0010, exp_rd: 8'h34};
    tbl[2] = '{addr: 2'd2, din: 8'hA5, ack_edges: 3, exp_upd: 4'b0100, exp_rd: 8'hA5};
    tbl[3] = '{addr: 2'd3, din: 8'hC3, ack_edges: 3, exp_upd: 4'b1000, exp_rd: 8'hC3};

    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_din = '0; err_clr = 1'b0; rd_addr = '0;
    b_req = 1'b0; b_addr = '0; b_din = '0; b_clr = 1'b0; b_rd_addr = '0;
    for (int i = 0; i < 4; i++) m4[i] = 8'h5C;

    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_ack", 32'(wr_ack), 32'h0);
    chk("rst_wr_err", 32'(wr_err), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    chk("rst_all_regs", all_regs, pack4());
    chk("rst_all_regs3", 32'(b_all), 32'h0);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk); rd_addr = 2'(a);
      @(posedge clk); #1;
      chk("rst_read", 32'(rd_data), 32'h5C);
    end

    // Table-driven writes: ack latency, one-cycle upd, ack release latency.
    foreach (tbl[k]) begin
      rise4(tbl[k].addr, tbl[k].din, n);
      chk("ack_rise_edges", 32'(n), 32'(tbl[k].ack_edges));
      chk("upd_before", 32'(upd), 32'h0);
      chk("all_regs_write", all_regs, pack4());
      @(posedge clk); #1;
      chk("upd_pulse", 32'(upd), 32'(tbl[k].exp_upd));
      @(posedge clk); #1;
      chk("upd_after", 32'(upd), 32'h0);
      fall4(n);
      chk("ack_fall_edges", 32'(n), 32'd3);
    end
    foreach (tbl[k]) begin
      @(negedge clk); rd_addr = tbl[k].addr;
      @(posedge clk); #1;
      chk("table_read", 32'(rd_data), 32'(tbl[k].exp_rd));
    end

    // Long request with bus changing after ack: exactly one write.
    c0 = upd_cnt;
    rise4(2'd1, 8'h5A, n);
    chk("hold_ack_edges", 32'(n), 32'd3);
    @(negedge clk); wr_din = 8'hFF; wr_addr = 2'd2;
    repeat (50) @(negedge clk);
    chk("hold_upd_count", 32'(upd_cnt - c0), 32'd1);
    chk("hold_all_regs", all_regs, pack4());
    fall4(n);
    chk("hold_ack_fall", 32'(n), 32'd3);

    // Read-before-write on the same register.
    rise4(2'd1, 8'h11, n);
    fall4(n);
    @(negedge clk); rd_addr = 2'd1;
    rise4(2'd1, 8'h3C, n);
    chk("rbw_old", 32'(rd_data), 32'h11);
    chk("rbw_reg", 32'(all_regs[15:8]), 32'h3C);
    @(posedge clk); #1;
    chk("rbw_new", 32'(rd_data), 32'h3C);
    fall4(n);

    // Reset while in ACK with request still high, then duplicate write.
    rise4(2'd0, 8'h77, n);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) m4[i] = 8'h5C;
    chk("midrst_ack", 32'(wr_ack), 32'h0);
    chk("midrst_regs", all_regs, pack4());
    @(negedge clk); rst = 1'b0;
    push(2'd0, 8'h77);
    wait_ack(1'b0, 1'b1, n);
    chk("midrst_rewrite_edges", 32'(n), 32'd3);
    chk("midrst_rewrite_regs", all_regs, pack4());
    fall4(n);

    // Range error on the 3-register bank.
    c0 = b_upd_cnt;
    rise3(2'd2, 8'h99, n);
    fall3(n);
    rise3(2'd3, 8'hE7, n);
    chk("err_ack_edges", 32'(n), 32'd3);
    chk("err_flag", 32'(b_err), 32'h1);
    fall3(n);
    chk("err_ack_fall", 32'(n), 32'd3);
    chk("err_regs_unchanged", 32'(b_all), 32'h990000);
    chk("err_no_upd", 32'(b_upd_cnt - c0), 32'd1);
    chk("err_sticky", 32'(b_err), 32'h1);
    @(negedge clk); b_rd_addr = 2'd3;
    @(posedge clk); #1;
    chk("read_out_of_range", 32'(b_rd_data), 32'h0);
    @(negedge clk); b_rd_addr = 2'd2;
    @(posedge clk); #1;
    chk("read_reg2_b", 32'(b_rd_data), 32'h99);
    @(negedge clk); b_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_cleared", 32'(b_err), 32'h0);
    @(negedge clk); b_clr = 1'b0;
    b_addr = 2'd3; b_req = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); b_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_set_ack", 32'(b_ack), 32'h1);
    chk("err_set_wins", 32'(b_err), 32'h1);
    @(negedge clk); b_clr = 1'b0;
    fall3(n);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
